rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: MAX_HOLD, 8, max consecutive grant cycles per owner when ARB_TIMEOUT_EN is defined (legal 2..255).
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  level request per requester; bit i = requester i.
REQ-005 Port: gnt  output  4  registered one-hot grant, or all-zero.
REQ-006 Port: owner  output  2  index of current/last grantee.
REQ-007 Port: busy  output  1  high when any gnt bit is high.
REQ-008 Port: timeout  output  1  one-cycle pulse on forced revocation.

Function
REQ-009 FSM SHALL have exactly three states: IDLE, GRANT, GAP.
REQ-010 IDLE: if req!=0, SHALL select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4), and at the next edge set gnt to that one-hot, owner to its index, and enter GRANT.
REQ-011 IDLE with req==0 SHALL remain in IDLE with gnt=0.
REQ-012 GRANT: while req[owner]=1 (and no timeout), gnt SHALL hold unchanged.
REQ-013 GRANT: when req[owner]=0 is sampled, at the next edge gnt SHALL become 0, ptr SHALL become (owner+1) mod 4, and the FSM SHALL enter GAP.
REQ-014 GAP SHALL last exactly one cycle with gnt=0, then return to IDLE; grants therefore never overlap and never switch owner directly.
REQ-015 Request-to-grant latency from IDLE SHALL be 1 cycle; minimum release-to-next-grant latency SHALL be 3 edges (GRANT->GAP->IDLE->GRANT).
REQ-016 A request withdrawn before being granted SHALL never be granted; no request is latched.
REQ-017 Requests from non-owners during GRANT/GAP SHALL not affect gnt or ptr.
REQ-018 busy SHALL equal |gnt, registered in step with gnt.
REQ-019 owner SHALL retain its value through GAP and IDLE until the next grant.
REQ-020 ptr SHALL change only on release or revocation, never on grant.

Reset
REQ-021 reset=1 at an edge SHALL force state=IDLE, gnt=4'b0000, owner=2'd0, busy=0, timeout=0, ptr=0, hold counter=0, regardless of current state.
REQ-022 Reset mid-grant SHALL drop gnt at that edge; first grant after reset SHALL favour requester 0.
REQ-023 req SHALL be ignored during cycles where reset=1.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN SHALL compile in the hold-time limiter.
REQ-025 With ARB_TIMEOUT_EN: an 8-bit hold counter SHALL clear on entering GRANT and increment each GRANT cycle; when it has counted MAX_HOLD grant cycles and any other req bit is 1, the next edge SHALL revoke (gnt=0, ptr=(owner+1) mod 4, enter GAP) and pulse timeout for exactly that one cycle.
REQ-026 With ARB_TIMEOUT_EN and no other requester pending, the owner SHALL keep the grant indefinitely; counter SHALL saturate at MAX_HOLD.
REQ-027 If release and timeout coincide, SHALL treat as normal release: timeout stays 0.
REQ-028 Without ARB_TIMEOUT_EN: no counter SHALL be synthesised, timeout SHALL be constant 0, grant holds until release.

Verification
REQ-029 Reset, then req=4'b1111 held: gnt=0001 one edge later; drop req[0] -> gap -> gnt=0010; sequence continues 0100, 1000, 0001.
REQ-030 After owner 2 releases, req=4'b0101: next grant SHALL be 0001? no -- ptr=3, scan 3,0 -> gnt=0001; then req=4'b0100 only -> gnt=0100 after gap.
REQ-031 Assert reset during gnt=0100: gnt=0000, owner=0, busy=0 at that edge; then req=4'b1010 -> gnt=0010.
REQ-032 ARB_TIMEOUT_EN, MAX_HOLD=8: req=0011 held -> gnt=0001 for exactly 8 cycles, timeout=1 one cycle with gnt=0000, then gnt=0010.
REQ-033 ARB_TIMEOUT_EN: req=0001 only for 20 cycles -> gnt=0001 throughout, timeout never 1; undefined macro, req=0011 for 20 cycles -> gnt=0001 throughout.
REQ-034 req pulse 4'b0100 for one cycle while in GAP: no grant results; gnt stays 0000.

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: one registered one-hot grant held until release, then a one-cycle gap.
// Optional hold-time limiter compiled in with `define ARB_TIMEOUT_EN (limit set by MAX_HOLD).
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] gnt_next;
  logic [1:0] owner_next;
  logic [1:0] ptr, ptr_next;
  logic [2:0] pick;
  logic       revoke;
  logic       timeout_next;

  // Returns {found, index} of the first set request scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + i[1:0];
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign pick = rr_pick(req, ptr);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  logic [7:0] hold_cnt, hold_cnt_next;
  logic       others_req;

  // gnt is the owner's one-hot while in GRANT, so this masks the owner out.
  assign others_req = |(req & ~gnt);
  // The current cycle is the MAX_HOLD-th grant cycle when hold_cnt == MAX_HOLD-1.
  assign revoke     = (state == GRANT) && req[owner] && others_req &&
                      (hold_cnt >= HOLD_LIM - 8'd1);

  always_comb begin
    hold_cnt_next = hold_cnt;
    if (state == IDLE) begin
      hold_cnt_next = 8'd0;
    end else if (state == GRANT && hold_cnt != HOLD_LIM) begin
      hold_cnt_next = hold_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_next;
      timeout  <= timeout_next;
    end
  end
`else
  assign revoke  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    owner_next   = owner;
    ptr_next     = ptr;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        gnt_next = 4'b0000;
        if (pick[2]) begin
          gnt_next   = 4'b0001 << pick[1:0];
          owner_next = pick[1:0];
          state_next = GRANT;
        end
      end
      GRANT: begin
        // A release takes priority over a coinciding revocation, so no timeout pulse then.
        if (!req[owner]) begin
          gnt_next   = 4'b0000;
          ptr_next   = owner + 2'd1;
          state_next = GAP;
        end else if (revoke) begin
          gnt_next     = 4'b0000;
          ptr_next     = owner + 2'd1;
          state_next   = GAP;
          timeout_next = 1'b1;
        end
      end
      GAP: begin
        gnt_next   = 4'b0000;
        state_next = IDLE;
      end
      default: begin
        gnt_next   = 4'b0000;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      owner <= 2'd0;
      ptr   <= 2'd0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      owner <= owner_next;
      ptr   <= ptr_next;
      busy  <= |gnt_next;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed-vector bench for rr_arbiter4: each vector is {reset, req} applied before an edge and
// the expected {gnt, owner, busy, timeout} observed just after it.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;

  logic [4:0] stim_q[$];
  logic [7:0] exp_q[$];

  rr_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .gnt(gnt),
    .owner(owner),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [4:0] s, input logic [7:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    int n = 0;
    add(5'b1_1111, 8'b0000_00_0_0);
    add(5'b1_1111, 8'b0000_00_0_0);
    while (stim_q.size() > 0) begin
      {reset, req} = stim_q.pop_front();
      exp = exp_q.pop_front();
      @(posedge clk); #1;
      vectors++;
      if ({gnt, owner, busy, timeout} !== exp) begin
        miscompares++;
        $display("FAIL reset[%0d]: got gnt=%b owner=%0d busy=%b timeout=%b, want %b", n, gnt, owner, busy, timeout, exp);
      end
      n++;
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp;
    int n = 0;
    add(5'b0_1111, 8'b0001_00_1_0);
    add(5'b0_1111, 8'b0001_00_1_0);
    add(5'b0_1110, 8'b0000_00_0_0);
    add(5'b0_1111, 8'b0000_00_0_0);
    add(5'b0_1111, 8'b0010_01_1_0);
    add(5'b0_1111, 8'b0010_01_1_0);
    add(5'b0_1101, 8'b0000_01_0_0);
    add(5'b0_1111, 8'b0000_01_0_0);
    add(5'b0_1111, 8'b0100_10_1_0);
    add(5'b0_1011, 8'b0000_10_0_0);
    add(5'b0_1111, 8'b0000_10_0_0);
    add(5'b0_1111, 8'b1000_11_1_0);
    add(5'b0_0111, 8'b0000_11_0_0);
    add(5'b0_1111, 8'b0000_11_0_0);
    add(5'b0_1111, 8'b0001_00_1_0);
    while (stim_q.size() > 0) begin
      {reset, req} = stim_q.pop_front();
      exp = exp_q.pop_front();
      @(posedge clk); #1;
      vectors++;
      if ({gnt, owner, busy, timeout} !== exp) begin
        miscompares++;
        $display("FAIL rotation[%0d]: got gnt=%b owner=%0d busy=%b timeout=%b, want %b", n, gnt, owner, busy, timeout, exp);
      end
      n++;
    end
  endtask

  task automatic test_ptr_wrap();
    logic [7:0] exp;
    int n = 0;
    add(5'b0_0100, 8'b0000_00_0_0);
    add(5'b0_0100, 8'b0000_00_0_0);
    add(5'b0_0100, 8'b0100_10_1_0);
    add(5'b0_0001, 8'b0000_10_0_0);
    add(5'b0_0101, 8'b0000_10_0_0);
    add(5'b0_0101, 8'b0001_00_1_0);
    add(5'b0_0100, 8'b0000_00_0_0);
    add(5'b0_0100, 8'b0000_00_0_0);
    add(5'b0_0100, 8'b0100_10_1_0);
    while (stim_q.size() > 0) begin
      {reset, req} = stim_q.pop_front();
      exp = exp_q.pop_front();
      @(posedge clk); #1;
      vectors++;
      if ({gnt, owner, busy, timeout} !== exp) begin
        miscompares++;
        $display("FAIL ptr_wrap[%0d]: got gnt=%b owner=%0d busy=%b timeout=%b, want %b", n, gnt, owner, busy, timeout, exp);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [7:0] exp;
    int n = 0;
    add(5'b1_0100, 8'b0000_00_0_0);
    add(5'b0_1010, 8'b0010_01_1_0);
    while (stim_q.size() > 0) begin
      {reset, req} = stim_q.pop_front();
      exp = exp_q.pop_front();
      @(posedge clk); #1;
      vectors++;
      if ({gnt, owner, busy, timeout} !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_grant[%0d]: got gnt=%b owner=%0d busy=%b timeout=%b, want %b", n, gnt, owner, busy, timeout, exp);
      end
      n++;
    end
  endtask

  task automatic test_non_owner_and_gap_pulse();
    logic [7:0] exp;
    int n = 0;
    add(5'b0_1011, 8'b0010_01_1_0);
    add(5'b0_0011, 8'b0010_01_1_0);
    add(5'b0_1111, 8'b0010_01_1_0);
    add(5'b0_0000, 8'b0000_01_0_0);
    add(5'b0_0100, 8'b0000_01_0_0);
    add(5'b0_0000, 8'b0000_01_0_0);
    add(5'b0_0000, 8'b0000_01_0_0);
    add(5'b0_1001, 8'b1000_11_1_0);
    add(5'b0_0000, 8'b0000_11_0_0);
    add(5'b0_0000, 8'b0000_11_0_0);
    while (stim_q.size() > 0) begin
      {reset, req} = stim_q.pop_front();
      exp = exp_q.pop_front();
      @(posedge clk); #1;
      vectors++;
      if ({gnt, owner, busy, timeout} !== exp) begin
        miscompares++;
        $display("FAIL non_owner_gap[%0d]: got gnt=%b owner=%0d busy=%b timeout=%b, want %b", n, gnt, owner, busy, timeout, exp);
      end
      n++;
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] exp;
    int n = 0;
    add(5'b1_0011, 8'b0000_00_0_0);
    repeat (8) add(5'b0_0011, 8'b0001_00_1_0);
    add(5'b0_0011, 8'b0000_00_0_1);
    add(5'b0_0011, 8'b0000_00_0_0);
    add(5'b0_0011, 8'b0010_01_1_0);
    repeat (7) add(5'b0_0011, 8'b0010_01_1_0);
    add(5'b0_0001, 8'b0000_01_0_0);
    add(5'b1_0001, 8'b0000_00_0_0);
    repeat (20) add(5'b0_0001, 8'b0001_00_1_0);
    while (stim_q.size() > 0) begin
      {reset, req} = stim_q.pop_front();
      exp = exp_q.pop_front();
      @(posedge clk); #1;
      vectors++;
      if ({gnt, owner, busy, timeout} !== exp) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got gnt=%b owner=%0d busy=%b timeout=%b, want %b", n, gnt, owner, busy, timeout, exp);
      end
      n++;
    end
  endtask
`else
  task automatic test_timeout();
    logic [7:0] exp;
    int n = 0;
    add(5'b1_0011, 8'b0000_00_0_0);
    repeat (20) add(5'b0_0011, 8'b0001_00_1_0);
    while (stim_q.size() > 0) begin
      {reset, req} = stim_q.pop_front();
      exp = exp_q.pop_front();
      @(posedge clk); #1;
      vectors++;
      if ({gnt, owner, busy, timeout} !== exp) begin
        miscompares++;
        $display("FAIL no_timeout[%0d]: got gnt=%b owner=%0d busy=%b timeout=%b, want %b", n, gnt, owner, busy, timeout, exp);
      end
      n++;
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    test_reset();
    test_rotation();
    test_ptr_wrap();
    test_reset_mid_grant();
    test_non_owner_and_gap_pulse();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
